// File: rtl/spi_master_dac.sv
// ---------------------------------------------------------------------------
// spi_master_dac
//   Write-only SPI master (mode 0, MSB first, active-low chip select) for a
//   serial DAC. After each frame, ldac is pulsed low to move the shifted word
//   to the DAC output. All outputs come straight from flip-flops.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, aborts any frame in flight
//   start  in   one-cycle transfer request, only honoured while idle
//   d_in   in   D_WIDTH-bit word, captured on the accepted start cycle
//   mosi   out  serial data, changes only on sclk falling edges
//   sclk   out  serial clock, idle low, half period CLK_DIV clk cycles
//   cs     out  chip select, active low
//   busy   out  high from acceptance until the ldac pulse ends
//   ldac   out  load-DAC strobe, active low, LDAC_CYCLES wide
// ---------------------------------------------------------------------------
module spi_master_dac #(
   parameter int D_WIDTH     = 16,
   parameter int CLK_DIV     = 2,
   parameter int LDAC_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [D_WIDTH-1:0] d_in,
   output logic               mosi,
   output logic               sclk,
   output logic               cs,
   output logic               busy,
   output logic               ldac
);

   // One counter serves the sclk half periods, the hold phase and the ldac
   // pulse, so it is sized for the longer of the two timings.
   localparam int CNT_MAX = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(D_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LOAD} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
   logic [D_WIDTH-1:0] shreg, shreg_nxt;
   logic               mosi_nxt, sclk_nxt, cs_nxt, busy_nxt, ldac_nxt;

   logic phase_done;
   logic load_done;
   logic last_bit;

   assign phase_done = (cnt == CNT_W'(CLK_DIV - 1));
   assign load_done  = (cnt == CNT_W'(LDAC_CYCLES - 1));
   assign last_bit   = (bit_cnt == BIT_W'(D_WIDTH - 1));

   // State and output registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         mosi    <= 1'b0;
         sclk    <= 1'b0;
         cs      <= 1'b1;
         busy    <= 1'b0;
         ldac    <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         mosi    <= mosi_nxt;
         sclk    <= sclk_nxt;
         cs      <= cs_nxt;
         busy    <= busy_nxt;
         ldac    <= ldac_nxt;
      end
   end

   // Next-state logic. The SHIFT exit happens on the falling sclk edge that
   // closes the last bit.
   always_comb begin
      // NOTE: a default assignment up front keeps every path driven, so no
      // latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (phase_done && sclk && last_bit) state_nxt = HOLD;
         HOLD:    if (phase_done) state_nxt = LOAD;
         LOAD:    if (load_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      cnt_nxt     = cnt;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      mosi_nxt    = mosi;
      sclk_nxt    = sclk;
      cs_nxt      = cs;
      busy_nxt    = busy;
      ldac_nxt    = ldac;
      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
            mosi_nxt    = 1'b0;
            sclk_nxt    = 1'b0;
            cs_nxt      = 1'b1;
            busy_nxt    = 1'b0;
            ldac_nxt    = 1'b1;
            if (start) begin
               // The MSB goes straight to mosi; the register keeps the
               // remaining bits left-aligned so its top bit is always next.
               shreg_nxt = d_in << 1;
               mosi_nxt  = d_in[D_WIDTH-1];
               cs_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         SHIFT: begin
            if (phase_done) begin
               cnt_nxt  = '0;
               sclk_nxt = ~sclk;
               if (sclk) begin
                  // Falling edge: present the next bit. After the last bit the
                  // register has been emptied, so mosi returns to 0.
                  mosi_nxt    = shreg[D_WIDTH-1];
                  shreg_nxt   = shreg << 1;
                  bit_cnt_nxt = bit_cnt + BIT_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (phase_done) begin
               cnt_nxt  = '0;
               cs_nxt   = 1'b1;
               ldac_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         LOAD: begin
            if (load_done) begin
               cnt_nxt  = '0;
               ldac_nxt = 1'b1;
               busy_nxt = 1'b0;
               mosi_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spi_master_dac.sv
// ---------------------------------------------------------------------------
// tb_spi_master_dac
//   Drives two spi_master_dac instances: the default configuration (16/2/2)
//   and a small one (8/1/1). A reference model tracks, per instance, how many
//   clk cycles have passed since the accepted start and derives every output
//   from that offset with plain arithmetic. A frame observer also rebuilds the
//   word from mosi at each rising sclk edge and checks it at the ldac strobe.
// ---------------------------------------------------------------------------
module tb_spi_master_dac;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [15:0] d0 = '0;
   logic [7:0]  d1 = '0;

   logic mosi0, sclk0, cs0, busy0, ldac0;
   logic mosi1, sclk1, cs1, busy1, ldac1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_master_dac #(.D_WIDTH(16), .CLK_DIV(2), .LDAC_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .d_in(d0),
      .mosi(mosi0), .sclk(sclk0), .cs(cs0), .busy(busy0), .ldac(ldac0)
   );

   spi_master_dac #(.D_WIDTH(8), .CLK_DIV(1), .LDAC_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .d_in(d1),
      .mosi(mosi1), .sclk(sclk1), .cs(cs1), .busy(busy1), .ldac(ldac1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          cfg_div [2] = '{2, 1};
   int          cfg_bits[2] = '{16, 8};
   int          cfg_ldac[2] = '{2, 1};

   bit          act      [2] = '{0, 0};
   int          k        [2] = '{0, 0};
   logic [15:0] data     [2];
   bit          exp_valid[2] = '{0, 0};

   function automatic int frame_len(int i);
      return 2 * cfg_div[i] * cfg_bits[i] + cfg_div[i] + cfg_ldac[i];
   endfunction

   // Advance the model by one clk edge using the inputs that edge samples.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic        st;
         logic [15:0] d;
         st = (i == 0) ? start0 : start1;
         d  = (i == 0) ? d0 : {8'h00, d1};
         if (reset) begin
            act[i]       = 0;
            exp_valid[i] = 0;
         end else if (st && (!act[i] || k[i] >= frame_len(i))) begin
            act[i]       = 1;
            k[i]         = 0;
            data[i]      = d;
            exp_valid[i] = 1;
         end else if (act[i]) begin
            k[i] = k[i] + 1;
         end
      end
   end

   // Compare one instance against the model, cycle by cycle.
   task automatic check_outputs(input int i, input logic cs, input logic sclk,
                                input logic mosi, input logic busy, input logic ldac);
      int  shift_len, cs_len, kk;
      bit  in_frame;
      shift_len = 2 * cfg_div[i] * cfg_bits[i];
      cs_len    = shift_len + cfg_div[i];
      kk        = k[i];
      in_frame  = act[i] && (kk < frame_len(i));
      if (!in_frame) begin
         check($sformatf("idle_cs%0d", i), cs, 1'b1);
         check($sformatf("idle_sclk%0d", i), sclk, 1'b0);
         check($sformatf("idle_mosi%0d", i), mosi, 1'b0);
         check($sformatf("idle_busy%0d", i), busy, 1'b0);
         check($sformatf("idle_ldac%0d", i), ldac, 1'b1);
      end else begin
         check($sformatf("busy%0d", i), busy, 1'b1);
         check($sformatf("cs%0d", i), cs, (kk < cs_len) ? 1'b0 : 1'b1);
         check($sformatf("ldac%0d", i), ldac, (kk < cs_len) ? 1'b1 : 1'b0);
         if (kk < shift_len) begin
            check($sformatf("sclk%0d", i), sclk, ((kk / cfg_div[i]) % 2) == 1);
            check($sformatf("mosi%0d", i), mosi,
                  data[i][cfg_bits[i] - 1 - kk / (2 * cfg_div[i])]);
         end else begin
            check($sformatf("sclk_tail%0d", i), sclk, 1'b0);
         end
      end
      if (ldac === 1'b0) check($sformatf("ldac_while_cs%0d", i), cs, 1'b1);
   endtask

   // ---------------- frame observer ----------------
   logic        prev_cs  [2] = '{1'b1, 1'b1};
   logic        prev_sclk[2] = '{1'b0, 1'b0};
   logic        prev_ldac[2] = '{1'b1, 1'b1};
   logic [15:0] cap      [2] = '{16'h0, 16'h0};
   int          edges    [2] = '{0, 0};
   int          frames   [2] = '{0, 0};

   task automatic observe(input int i, input logic cs, input logic sclk,
                          input logic mosi, input logic ldac);
      if (prev_cs[i] && !cs) begin
         cap[i]   = '0;
         edges[i] = 0;
      end
      if (!prev_sclk[i] && sclk) begin
         cap[i]   = {cap[i][14:0], mosi};
         edges[i] = edges[i] + 1;
      end
      if (prev_ldac[i] && !ldac) begin
         frames[i] = frames[i] + 1;
         check($sformatf("frame_owner%0d", i), exp_valid[i], 1'b1);
         check($sformatf("frame_edges%0d", i), edges[i], cfg_bits[i]);
         check($sformatf("frame_word%0d", i), cap[i], data[i]);
         exp_valid[i] = 0;
      end
      prev_cs[i]   = cs;
      prev_sclk[i] = sclk;
      prev_ldac[i] = ldac;
   endtask

   always @(negedge clk) begin
      check_outputs(0, cs0, sclk0, mosi0, busy0, ldac0);
      check_outputs(1, cs1, sclk1, mosi1, busy1, ldac1);
      observe(0, cs0, sclk0, mosi0, ldac0);
      observe(1, cs1, sclk1, mosi1, ldac1);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse0(input logic [15:0] d);
      d0 = d; start0 = 1'b1; cyc(); start0 = 1'b0;
   endtask

   initial begin
      int frames_before;

      // Reset held, start pulses during reset must be ignored; start stays
      // high on the last edge that still sees reset.
      cyc(3);
      start0 = 1'b1; start1 = 1'b1; d0 = 16'hDEAD; d1 = 8'hBE;
      cyc(2);
      reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
      cyc(4);
      check("no_frame_in_reset", frames[0] + frames[1], 0);

      // Basic frame.
      pulse0(16'hA5A5);
      cyc(75);
      check("basic_frames", frames[0], 1);

      // Start during busy is ignored.
      pulse0(16'h1234);
      cyc(20);
      pulse0(16'hFFFF);
      cyc(60);
      check("busy_ignore_frames", frames[0], 2);

      // Back-to-back with start held high; d_in changes after acceptance.
      d0 = 16'h8001; start0 = 1'b1;
      cyc(6);
      d0 = 16'h7FFE;
      cyc(100);
      start0 = 1'b0;
      cyc(80);
      check("back_to_back_frames", frames[0], 4);

      // Reset after five sclk rising edges: no ldac pulse, then a clean frame.
      frames_before = frames[0];
      pulse0(16'h5A3C);
      cyc(18);
      reset = 1'b1; cyc(); reset = 1'b0;
      cyc(3);
      check("abort_no_ldac", frames[0], frames_before);
      pulse0(16'h0F0F);
      cyc(75);
      check("after_abort_frame", frames[0], frames_before + 1);

      // Small configuration.
      d1 = 8'hC3; start1 = 1'b1; cyc(); start1 = 1'b0;
      cyc(25);
      check("small_frame", frames[1], 1);

      // Randomized traffic on both instances, including starts while busy,
      // d_in churn and occasional resets.
      for (int n = 0; n < 1500; n++) begin
         d0     = 16'($urandom);
         d1     = 8'($urandom);
         start0 = ($urandom_range(0, 19) == 0);
         start1 = ($urandom_range(0, 9) == 0);
         reset  = ($urandom_range(0, 399) == 0);
         cyc();
      end
      start0 = 1'b0; start1 = 1'b0; reset = 1'b0;
      cyc(80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
